// File: rtl/shift_add_seq_mul.sv
// Shift-add constant-multiply sequencer: one sample in, NCOEF products out
// (sample*COEF[0..NCOEF-1]) over a valid/ready stream with backpressure.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no sample held, out_valid=0, ready for input
// RUN   | sample held, current product valid on outputs
module shift_add_seq_mul #(
   parameter int                     DW    = 8,
   parameter int                     CW    = 4,
   parameter int                     NCOEF = 4,
   parameter logic [NCOEF*CW-1:0]    COEFS = {4'd8, 4'd7, 4'd3, 4'd1},
   localparam int                    OW    = DW + CW,
   localparam int                    IW    = (NCOEF > 1) ? $clog2(NCOEF) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] d,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out,
   output logic [IW-1:0] out_idx,
   output logic          out_last,
   output logic          busy
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]    r_state;
   logic [DW-1:0] r_sample;
   logic [OW-1:0] r_out;
   logic [IW-1:0] r_out_idx;
   logic          r_out_last;

   logic          w_fire;
   logic          w_accept;
   logic          w_in_ready;
   logic [IW-1:0] w_idx_next;
   logic [IW-1:0] w_sel_idx;
   logic [DW-1:0] w_sel_sample;
   logic [CW-1:0] w_sel_coef;
   logic [OW-1:0] w_product;

   function automatic logic [OW-1:0] f_shift_add(input logic [DW-1:0] sample,
                                                 input logic [CW-1:0] coef);
      logic [OW-1:0] acc;
      acc = '0;
      for (int b = 0; b < CW; b++) begin
         if (coef[b]) acc = acc + ({{CW{1'b0}}, sample} << b);
      end
      return acc;
   endfunction

   assign w_fire     = (r_state == ST_RUN) & out_ready;
   assign w_in_ready = (r_state == ST_IDLE) | (w_fire & r_out_last);
   assign w_accept   = in_valid & w_in_ready;
   assign w_idx_next = r_out_idx + IW'(1);

   // A new sample always restarts at index 0; d only reaches the datapath on accept.
   assign w_sel_idx    = w_accept ? '0 : w_idx_next;
   assign w_sel_sample = w_accept ? d  : r_sample;

   always_comb begin
      w_sel_coef = '0;
      for (int i = 0; i < NCOEF; i++) begin
         if (w_sel_idx == IW'(i)) w_sel_coef = COEFS[i*CW +: CW];
      end
   end

   assign w_product = f_shift_add(w_sel_sample, w_sel_coef);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_sample   <= '0;
         r_out      <= '0;
         r_out_idx  <= '0;
         r_out_last <= 1'b0;
      end else if (w_accept) begin
         r_state    <= ST_RUN;
         r_sample   <= d;
         r_out      <= w_product;
         r_out_idx  <= '0;
         r_out_last <= (NCOEF == 1);
      end else if (w_fire && !r_out_last) begin
         r_out      <= w_product;
         r_out_idx  <= w_idx_next;
         r_out_last <= (w_idx_next == IW'(NCOEF - 1));
      end else if (w_fire) begin
         r_state <= ST_IDLE;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = (r_state == ST_RUN);
   assign out       = r_out;
   assign out_idx   = r_out_idx;
   assign out_last  = r_out_last;
   assign busy      = (r_state == ST_RUN);

endmodule

// File: tb/tb_shift_add_seq_mul.sv
// Directed bench for shift_add_seq_mul: default 4-coefficient instance plus a
// single-coefficient (COEF=0) instance for back-to-back operation.
module tb_shift_add_seq_mul;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
   logic [7:0]  d;
   logic [11:0] out;
   logic [1:0]  out_idx;

   logic        in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;
   logic [7:0]  d1;
   logic [11:0] out1;
   logic [0:0]  out_idx1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   shift_add_seq_mul u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .d(d),
      .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_idx(out_idx),
      .out_last(out_last), .busy(busy)
   );

   shift_add_seq_mul #(.NCOEF(1), .COEFS(4'd0)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .d(d1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out(out1), .out_idx(out_idx1),
      .out_last(out_last1), .busy(busy1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic check_prod(input string tag, input int want_out, input int want_idx,
                             input bit want_last);
      check({tag, " valid"}, 32'(out_valid), 32'd1);
      check({tag, " out"},   32'(out),       32'(want_out));
      check({tag, " idx"},   32'(out_idx),   32'(want_idx));
      check({tag, " last"},  32'(out_last),  32'(want_last));
      check({tag, " busy"},  32'(busy),      32'd1);
   endtask

   task automatic check_idle(input string tag);
      check({tag, " valid"},    32'(out_valid), 32'd0);
      check({tag, " busy"},     32'(busy),      32'd0);
      check({tag, " in_ready"}, 32'(in_ready),  32'd1);
   endtask

   // Accept one sample with out_ready=1 and check the full product run.
   task automatic run_sample(input string tag, input logic [7:0] sample,
                             input int p0, input int p1, input int p2, input int p3);
      int want[4];
      want = '{p0, p1, p2, p3};
      in_valid = 1'b1; d = sample; out_ready = 1'b1;
      #1 check({tag, " accept ready"}, 32'(in_ready), 32'd1);
      tick;
      in_valid = 1'b0; d = 'x;
      for (int i = 0; i < 4; i++) begin
         check_prod($sformatf("%s p%0d", tag, i), want[i], i, i == 3);
         check($sformatf("%s p%0d in_ready", tag, i), 32'(in_ready), 32'(i == 3));
         if (i < 3) tick;
      end
      tick;
      check_idle({tag, " end"});
   endtask

   initial begin
      in_valid = 1'b0; d = 'x; out_ready = 1'b0;
      in_valid1 = 1'b0; d1 = 'x; out_ready1 = 1'b0;
      #12;
      check("rst out",   32'(out),       32'd0);
      check("rst idx",   32'(out_idx),   32'd0);
      check("rst last",  32'(out_last),  32'd0);
      check("rst valid", 32'(out_valid), 32'd0);
      check("rst busy",  32'(busy),      32'd0);
      check("rst valid1", 32'(out_valid1), 32'd0);
      tick; rst = 1'b1;
      tick;
      check_idle("post-rst");

      // 1 and 2: plain runs
      run_sample("t1 d=5",   8'd5,   5,   15,  35,   40);
      run_sample("t2 d=255", 8'd255, 255, 765, 1785, 2040);

      // 3: stall at index 1, a competing sample must be ignored
      in_valid = 1'b1; d = 8'd9; out_ready = 1'b1;
      tick;
      in_valid = 1'b0; d = 'x;
      check_prod("t3 p0", 9, 0, 1'b0);
      tick;
      check_prod("t3 p1", 27, 1, 1'b0);
      out_ready = 1'b0; in_valid = 1'b1; d = 8'd77;
      for (int s = 0; s < 3; s++) begin
         #1 check($sformatf("t3 stall%0d in_ready", s), 32'(in_ready), 32'd0);
         tick;
         check_prod($sformatf("t3 stall%0d", s), 27, 1, 1'b0);
      end
      out_ready = 1'b1; in_valid = 1'b0; d = 'x;
      tick;
      check_prod("t3 p2", 63, 2, 1'b0);
      tick;
      check_prod("t3 p3", 72, 3, 1'b1);
      tick;
      check_idle("t3 end");

      // 4: back-to-back samples, no bubble between 40 and 6
      in_valid = 1'b1; d = 8'd5; out_ready = 1'b1;
      tick;
      d = 8'd6;
      check_prod("t4 a0", 5, 0, 1'b0);
      check("t4 a0 in_ready", 32'(in_ready), 32'd0);
      tick;
      check_prod("t4 a1", 15, 1, 1'b0);
      check("t4 a1 in_ready", 32'(in_ready), 32'd0);
      tick;
      check_prod("t4 a2", 35, 2, 1'b0);
      tick;
      check_prod("t4 a3", 40, 3, 1'b1);
      check("t4 a3 in_ready", 32'(in_ready), 32'd1);
      tick;
      in_valid = 1'b0; d = 'x;
      check_prod("t4 b0", 6, 0, 1'b0);
      check("t4 b0 in_ready", 32'(in_ready), 32'd0);
      tick;
      check_prod("t4 b1", 18, 1, 1'b0);
      tick;
      check_prod("t4 b2", 42, 2, 1'b0);
      tick;
      check_prod("t4 b3", 48, 3, 1'b1);
      tick;
      check_idle("t4 end");

      // 5: async reset in the middle of a run
      in_valid = 1'b1; d = 8'd5; out_ready = 1'b1;
      tick;
      in_valid = 1'b0; d = 'x;
      tick;
      tick;
      check_prod("t5 pre", 35, 2, 1'b0);
      rst = 1'b0;
      #1;
      check("t5 rst out",   32'(out),       32'd0);
      check("t5 rst idx",   32'(out_idx),   32'd0);
      check("t5 rst last",  32'(out_last),  32'd0);
      check("t5 rst valid", 32'(out_valid), 32'd0);
      check("t5 rst busy",  32'(busy),      32'd0);
      tick;
      rst = 1'b1;
      tick;
      check_idle("t5 post");
      run_sample("t5 d=3", 8'd3, 3, 9, 21, 24);

      // 6: single zero coefficient, accept every cycle
      in_valid1 = 1'b1; d1 = 8'd200; out_ready1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick;
         d1 = 8'(201 + k);
         check($sformatf("t6 c%0d valid", k),    32'(out_valid1), 32'd1);
         check($sformatf("t6 c%0d out", k),      32'(out1),       32'd0);
         check($sformatf("t6 c%0d last", k),     32'(out_last1),  32'd1);
         check($sformatf("t6 c%0d idx", k),      32'(out_idx1),   32'd0);
         check($sformatf("t6 c%0d in_ready", k), 32'(in_ready1),  32'd1);
      end
      in_valid1 = 1'b0; d1 = 'x;
      tick;
      check("t6 end valid", 32'(out_valid1), 32'd0);
      check("t6 end busy",  32'(busy1),      32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
